// File: rtl/sal_resp_gen_pkg.sv
// Shared types and width defaults for the SAL return path (AXI R/B generation).
package sal_resp_gen_pkg;

  // DRAM/AXI width defaults used by the response generator.
  localparam int SAL_ID_W        = 4;
  localparam int SAL_LEN_W       = 4;
  localparam int SAL_DATA_W      = 64;
  localparam int SAL_RDBUF_DEPTH = 32;
  localparam int SAL_TAG_DEPTH   = 8;
  localparam int SAL_BRESP_DEPTH = 8;

  // AXI response encodings.
  typedef enum logic [1:0] {
    SAL_RESP_OKAY   = 2'b00,
    SAL_RESP_SLVERR = 2'b10
  } axi_resp_e;

  // Read burst tag at the default widths: AXI ID plus AXI len.
  typedef struct packed {
    logic [SAL_ID_W-1:0]  id;
    logic [SAL_LEN_W-1:0] len;
  } rd_tag_t;

  // Number of beats in a burst given its AXI len field.
  function automatic int burst_beats(input int len);
    return len + 1;
  endfunction

endpackage

// File: rtl/sal_resp_gen_if.sv
// Bundles the read-command, DRAM read-data, write-completion and AXI R/B signals.
interface sal_resp_gen_if #(
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 64
);
  logic              rd_cmd_valid;
  logic              rd_cmd_ready;
  logic [ID_W-1:0]   rd_cmd_id;
  logic [LEN_W-1:0]  rd_cmd_len;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              wr_done_valid;
  logic              wr_done_ready;
  logic [ID_W-1:0]   wr_done_id;
  logic              axi_rvalid;
  logic              axi_rready;
  logic [ID_W-1:0]   axi_rid;
  logic [DATA_W-1:0] axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rlast;
  logic              axi_bvalid;
  logic              axi_bready;
  logic [ID_W-1:0]   axi_bid;
  logic [1:0]        axi_bresp;

  // Response generator side.
  modport slave (
    input  rd_cmd_valid, rd_cmd_id, rd_cmd_len, rdata_valid, rdata,
    input  wr_done_valid, wr_done_id, axi_rready, axi_bready,
    output rd_cmd_ready, wr_done_ready,
    output axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
    output axi_bvalid, axi_bid, axi_bresp
  );

  // Bank controller / DRAM path / AXI port side.
  modport master (
    output rd_cmd_valid, rd_cmd_id, rd_cmd_len, rdata_valid, rdata,
    output wr_done_valid, wr_done_id, axi_rready, axi_bready,
    input  rd_cmd_ready, wr_done_ready,
    input  axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
    input  axi_bvalid, axi_bid, axi_bresp
  );
endinterface

// File: rtl/sal_sync_fifo.sv
// Single-clock FIFO with full/empty flags; the head entry is read straight from
// the storage register, so a word written at cycle N is visible at cycle N+1.
module sal_sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    cnt_q;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage write.
  // NOTE: the data array has no reset; empty/full come from the pointers, so
  // stale contents are never observed and the array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/sal_resp_gen.sv
// Return path: turns read commands plus DRAM read beats into AXI R bursts with
// RID/RLAST, and write completions into AXI B responses. Read admission uses a
// beat-credit reservation so the unstallable DRAM data path never overflows.
module sal_resp_gen
  import sal_resp_gen_pkg::*;
#(
  parameter int ID_W        = SAL_ID_W,
  parameter int LEN_W       = SAL_LEN_W,
  parameter int DATA_W      = SAL_DATA_W,
  parameter int RDBUF_DEPTH = SAL_RDBUF_DEPTH,
  parameter int TAG_DEPTH   = SAL_TAG_DEPTH,
  parameter int BRESP_DEPTH = SAL_BRESP_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  sal_resp_gen_if.slave  bus
);
  localparam int RES_W = $clog2(RDBUF_DEPTH) + 1;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } tag_t;

  tag_t              tag_in, tag_head;
  logic              tag_full, tag_empty;
  logic [DATA_W-1:0] data_head;
  logic              data_full, data_empty;
  logic [ID_W-1:0]   b_head;
  logic              b_full, b_empty;

  logic              r_valid, r_last;
  logic              cmd_fire, r_fire, wr_fire, b_fire;
  logic [RES_W-1:0]  reserved_q, reserved_d;
  logic [RES_W-1:0]  free_beats, need_beats;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;

  // Admission: a burst needs a tag slot and len+1 unreserved buffer entries.
  assign free_beats       = RES_W'(RDBUF_DEPTH) - reserved_q;
  assign need_beats       = RES_W'(bus.rd_cmd_len) + RES_W'(1);
  assign bus.rd_cmd_ready = !tag_full && (free_beats >= need_beats);
  assign cmd_fire         = bus.rd_cmd_valid && bus.rd_cmd_ready;
  assign tag_in           = '{id: bus.rd_cmd_id, len: bus.rd_cmd_len};

  // R channel is driven straight from the FIFO heads, which only move on a
  // handshake, so the beat stays stable while the master stalls.
  assign r_valid        = !data_empty && !tag_empty;
  assign r_last         = r_valid && (beat_cnt_q == tag_head.len);
  assign r_fire         = r_valid && bus.axi_rready;
  assign bus.axi_rvalid = r_valid;
  assign bus.axi_rid    = tag_head.id;
  assign bus.axi_rdata  = data_head;
  assign bus.axi_rresp  = SAL_RESP_OKAY;
  assign bus.axi_rlast  = r_last;

  // B channel.
  assign bus.wr_done_ready = !b_full;
  assign wr_fire           = bus.wr_done_valid && !b_full;
  assign bus.axi_bvalid    = !b_empty;
  assign bus.axi_bid       = b_head;
  assign bus.axi_bresp     = SAL_RESP_OKAY;
  assign b_fire            = !b_empty && bus.axi_bready;

  sal_sync_fifo #(.DEPTH(TAG_DEPTH), .DATA_W($bits(tag_t))) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_fire),
    .din_i   (tag_in),
    .pop_i   (r_fire && r_last),
    .dout_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  sal_sync_fifo #(.DEPTH(RDBUF_DEPTH), .DATA_W(DATA_W)) u_data_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.rdata_valid),
    .din_i   (bus.rdata),
    .pop_i   (r_fire),
    .dout_o  (data_head),
    .full_o  (data_full),
    .empty_o (data_empty)
  );

  sal_sync_fifo #(.DEPTH(BRESP_DEPTH), .DATA_W(ID_W)) u_b_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_fire),
    .din_i   (bus.wr_done_id),
    .pop_i   (b_fire),
    .dout_o  (b_head),
    .full_o  (b_full),
    .empty_o (b_empty)
  );

  // Next-state for the credit reservation and the in-burst beat counter.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    reserved_d = reserved_q;
    beat_cnt_d = beat_cnt_q;
    if (cmd_fire) reserved_d = reserved_d + need_beats;
    if (r_fire) begin
      reserved_d = reserved_d - RES_W'(1);
      beat_cnt_d = r_last ? '0 : beat_cnt_q + 1'b1;
    end
  end

  // Credit and beat-counter registers; reset drops every outstanding reservation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reserved_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      reserved_q <= reserved_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // The credit scheme must keep DRAM beats inside the buffer and behind a tag.
  a_no_rdata_overflow : assert property (
    @(posedge clk) disable iff (!rst_n) bus.rdata_valid |-> !data_full);
  a_rdata_has_tag : assert property (
    @(posedge clk) disable iff (!rst_n) bus.rdata_valid |-> !tag_empty);

endmodule

// File: tb/tb_sal_resp_gen.sv
// Directed bench for sal_resp_gen with a queue-based reference model checked every cycle.
module tb_sal_resp_gen;
  import sal_resp_gen_pkg::*;

  localparam int ID_W        = 4;
  localparam int LEN_W       = 4;
  localparam int DATA_W      = 64;
  localparam int RDBUF_DEPTH = 32;
  localparam int TAG_DEPTH   = 8;
  localparam int BRESP_DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sal_resp_gen_if #(.ID_W(ID_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

  sal_resp_gen #(
    .ID_W(ID_W), .LEN_W(LEN_W), .DATA_W(DATA_W),
    .RDBUF_DEPTH(RDBUF_DEPTH), .TAG_DEPTH(TAG_DEPTH), .BRESP_DEPTH(BRESP_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Each accepted burst is flattened into its expected beats {id, last};
  // outstanding beats are exactly the reserved credit.
  typedef struct { logic [ID_W-1:0] id; logic last; } exp_beat_t;
  typedef struct { logic [ID_W-1:0] id; logic [DATA_W-1:0] data; logic last; } r_rec_t;

  exp_beat_t         beat_q[$];
  logic [DATA_W-1:0] data_q[$];
  logic [ID_W-1:0]   b_q[$];
  int                bursts_open = 0;
  r_rec_t            r_log[$];
  logic [ID_W-1:0]   b_log[$];

  function automatic void expand(input rd_tag_t t);
    for (int i = 0; i < burst_beats(int'(t.len)); i++)
      beat_q.push_back('{id: t.id, last: (i == int'(t.len))});
  endfunction

  // Compare process: checks outputs against the model, then advances the model
  // to what the coming clock edge does.
  always @(negedge clk) begin
    bit exp_rvalid, exp_cmd_ready, exp_wr_ready, exp_bvalid;
    bit r_fire, cmd_fire, data_push, wr_fire, b_fire;
    rd_tag_t t;
    if (!rst_n) begin
      beat_q.delete();
      data_q.delete();
      b_q.delete();
      bursts_open = 0;
    end else begin
      exp_rvalid    = (data_q.size() != 0) && (beat_q.size() != 0);
      exp_cmd_ready = (bursts_open < TAG_DEPTH) &&
                      ((RDBUF_DEPTH - beat_q.size()) >= burst_beats(int'(bus.rd_cmd_len)));
      exp_wr_ready  = b_q.size() < BRESP_DEPTH;
      exp_bvalid    = b_q.size() != 0;

      check("rvalid", bus.axi_rvalid, exp_rvalid);
      check("rd_cmd_ready", bus.rd_cmd_ready, exp_cmd_ready);
      check("wr_done_ready", bus.wr_done_ready, exp_wr_ready);
      check("bvalid", bus.axi_bvalid, exp_bvalid);
      if (exp_rvalid) begin
        check("rid", bus.axi_rid, beat_q[0].id);
        check("rdata", bus.axi_rdata, data_q[0]);
        check("rlast", bus.axi_rlast, beat_q[0].last);
        check("rresp", bus.axi_rresp, SAL_RESP_OKAY);
      end
      if (exp_bvalid) begin
        check("bid", bus.axi_bid, b_q[0]);
        check("bresp", bus.axi_bresp, SAL_RESP_OKAY);
      end

      r_fire    = exp_rvalid && bus.axi_rready;
      cmd_fire  = bus.rd_cmd_valid && exp_cmd_ready;
      data_push = bus.rdata_valid && (data_q.size() < RDBUF_DEPTH);
      wr_fire   = bus.wr_done_valid && exp_wr_ready;
      b_fire    = exp_bvalid && bus.axi_bready;

      if (r_fire) begin
        r_log.push_back('{id: bus.axi_rid, data: bus.axi_rdata, last: bus.axi_rlast});
        if (beat_q[0].last) bursts_open--;
        void'(beat_q.pop_front());
        void'(data_q.pop_front());
      end
      if (cmd_fire) begin
        t.id  = bus.rd_cmd_id;
        t.len = bus.rd_cmd_len;
        expand(t);
        bursts_open++;
      end
      if (data_push) data_q.push_back(bus.rdata);
      if (b_fire) begin
        b_log.push_back(bus.axi_bid);
        void'(b_q.pop_front());
      end
      if (wr_fire) b_q.push_back(bus.wr_done_id);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len);
    bus.rd_cmd_valid = 1'b1;
    bus.rd_cmd_id    = id;
    bus.rd_cmd_len   = len;
    #1;
    for (int n = 0; n < 200; n++) begin
      if (bus.rd_cmd_ready) begin
        tick();
        bus.rd_cmd_valid = 1'b0;
        return;
      end
      tick();
    end
    bus.rd_cmd_valid = 1'b0;
    timeout("rd_cmd_accept");
  endtask

  task automatic send_wr(input logic [ID_W-1:0] id);
    bus.wr_done_valid = 1'b1;
    bus.wr_done_id    = id;
    #1;
    for (int n = 0; n < 200; n++) begin
      if (bus.wr_done_ready) begin
        tick();
        bus.wr_done_valid = 1'b0;
        return;
      end
      tick();
    end
    bus.wr_done_valid = 1'b0;
    timeout("wr_done_accept");
  endtask

  task automatic beat(input logic [DATA_W-1:0] d);
    bus.rdata_valid = 1'b1;
    bus.rdata       = d;
    tick();
    bus.rdata_valid = 1'b0;
  endtask

  task automatic wait_r_drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (beat_q.size() == 0) return;
      tick();
    end
    timeout("r_drain");
  endtask

  task automatic wait_b_drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (b_q.size() == 0) return;
      tick();
    end
    timeout("b_drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    rst_n             = 1'b0;
    bus.rd_cmd_valid  = 1'b0;
    bus.rd_cmd_id     = '0;
    bus.rd_cmd_len    = '0;
    bus.rdata_valid   = 1'b0;
    bus.rdata         = '0;
    bus.wr_done_valid = 1'b0;
    bus.wr_done_id    = '0;
    bus.axi_rready    = 1'b0;
    bus.axi_bready    = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("reset_rvalid", bus.axi_rvalid, 1'b0);
    check("reset_rlast", bus.axi_rlast, 1'b0);
    check("reset_bvalid", bus.axi_bvalid, 1'b0);
    check("reset_rd_cmd_ready", bus.rd_cmd_ready, 1'b1);
    check("reset_wr_done_ready", bus.wr_done_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Single read burst, id 3 len 3, no backpressure.
    r_log.delete();
    bus.axi_rready = 1'b1;
    issue_cmd(4'd3, 4'd3);
    for (int i = 0; i < 4; i++) beat(64'hD0 + 64'(i));
    wait_r_drain(50);
    check("single_count", r_log.size(), 4);
    for (int i = 0; i < 4 && i < r_log.size(); i++) begin
      check("single_rid", r_log[i].id, 4'd3);
      check("single_rdata", r_log[i].data, 64'hD0 + 64'(i));
      check("single_rlast", r_log[i].last, (i == 3));
    end
    #1;
    check("single_ready_back", bus.rd_cmd_ready, 1'b1);

    // Same burst with rready pattern 1,0,0,1.
    r_log.delete();
    issue_cmd(4'd3, 4'd3);
    for (int i = 0; i < 16; i++) begin
      bus.axi_rready  = ((i % 4) == 0) || ((i % 4) == 3);
      bus.rdata_valid = (i < 4);
      bus.rdata       = 64'hB0 + 64'(i);
      tick();
    end
    bus.rdata_valid = 1'b0;
    bus.axi_rready  = 1'b1;
    wait_r_drain(50);
    check("bp_count", r_log.size(), 4);
    for (int i = 0; i < 4 && i < r_log.size(); i++) begin
      check("bp_rdata", r_log[i].data, 64'hB0 + 64'(i));
      check("bp_rlast", r_log[i].last, (i == 3));
    end

    // Ordering: id 1 len 1 then id 2 len 0, data back to back.
    r_log.delete();
    issue_cmd(4'd1, 4'd1);
    issue_cmd(4'd2, 4'd0);
    for (int i = 0; i < 3; i++) beat(64'hC0 + 64'(i));
    wait_r_drain(50);
    check("ord_count", r_log.size(), 3);
    if (r_log.size() == 3) begin
      check("ord_rid0", r_log[0].id, 4'd1);
      check("ord_rlast0", r_log[0].last, 1'b0);
      check("ord_rid1", r_log[1].id, 4'd1);
      check("ord_rlast1", r_log[1].last, 1'b1);
      check("ord_rid2", r_log[2].id, 4'd2);
      check("ord_rlast2", r_log[2].last, 1'b1);
      check("ord_rdata2", r_log[2].data, 64'hC2);
    end

    // Credit limit: two 16-beat bursts reserve the whole buffer.
    r_log.delete();
    bus.axi_rready = 1'b0;
    issue_cmd(4'd10, 4'd15);
    issue_cmd(4'd11, 4'd15);
    bus.rd_cmd_len = 4'd0;
    #1;
    check("credit_full_ready", bus.rd_cmd_ready, 1'b0);
    for (int i = 0; i < 32; i++) beat(64'h100 + 64'(i));
    check("credit_full_ready_data", bus.rd_cmd_ready, 1'b0);
    bus.axi_rready = 1'b1;
    tick();
    bus.axi_rready = 1'b0;
    #1;
    check("credit_one_free", bus.rd_cmd_ready, 1'b1);
    issue_cmd(4'd7, 4'd0);
    beat(64'h700);
    bus.axi_rready = 1'b1;
    wait_r_drain(100);
    check("credit_count", r_log.size(), 33);
    if (r_log.size() == 33) begin
      check("credit_last15", r_log[15].last, 1'b1);
      check("credit_id16", r_log[16].id, 4'd11);
      check("credit_last31", r_log[31].last, 1'b1);
      check("credit_id32", r_log[32].id, 4'd7);
      check("credit_data32", r_log[32].data, 64'h700);
    end

    // Write responses.
    b_log.delete();
    bus.axi_bready = 1'b0;
    send_wr(4'd5);
    send_wr(4'd6);
    send_wr(4'd7);
    tick();
    tick();
    check("wr_hold_bvalid", bus.axi_bvalid, 1'b1);
    check("wr_hold_bid", bus.axi_bid, 4'd5);
    bus.axi_bready = 1'b1;
    wait_b_drain(50);
    check("wr_count", b_log.size(), 3);
    if (b_log.size() == 3) begin
      check("wr_bid0", b_log[0], 4'd5);
      check("wr_bid1", b_log[1], 4'd6);
      check("wr_bid2", b_log[2], 4'd7);
    end
    bus.axi_bready = 1'b0;
    for (int i = 0; i < 8; i++) send_wr(4'(8 + i));
    #1;
    check("wr_fill_ready", bus.wr_done_ready, 1'b0);
    check("wr_fill_bid", bus.axi_bid, 4'd8);
    bus.axi_bready = 1'b1;
    wait_b_drain(50);

    // Reset mid-burst.
    bus.axi_bready = 1'b0;
    bus.axi_rready = 1'b1;
    send_wr(4'd12);
    issue_cmd(4'd9, 4'd3);
    beat(64'hE0);
    beat(64'hE1);
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_rvalid", bus.axi_rvalid, 1'b0);
    check("rst_bvalid", bus.axi_bvalid, 1'b0);
    check("rst_rlast", bus.axi_rlast, 1'b0);
    check("rst_rd_cmd_ready", bus.rd_cmd_ready, 1'b1);
    rst_n = 1'b1;
    tick();
    r_log.delete();
    issue_cmd(4'd4, 4'd1);
    beat(64'hF0);
    beat(64'hF1);
    wait_r_drain(50);
    check("post_rst_count", r_log.size(), 2);
    if (r_log.size() == 2) begin
      check("post_rst_rid", r_log[0].id, 4'd4);
      check("post_rst_rlast0", r_log[0].last, 1'b0);
      check("post_rst_rlast1", r_log[1].last, 1'b1);
      check("post_rst_rdata0", r_log[0].data, 64'hF0);
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
